// File: rtl/avg_uart_pkg.sv
// +----------------------------------------------------------------------+
// | avg_uart_pkg                                                         |
// | ASCII constants, formatter state encoding and nibble-to-hex helper.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package avg_uart_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIGIT = 3'd2,
        S_CR    = 3'd3,
        S_LF    = 3'd4
    } state_t;

    function automatic logic [7:0] nib2asc(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASC_0 + {4'd0, nib};
        else
            return ASC_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// +----------------------------------------------------------------------+
// | uart_tx_byte                                                         |
// | Single-byte UART transmitter, 8N1 or 8E1 with AVG_UART_PARITY_EN.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_byte #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int c_DIV  = CLK_HZ / BAUD;
    localparam int c_CNTW = $clog2(c_DIV);
`ifdef AVG_UART_PARITY_EN
    localparam int c_NBITS = 11;
`else
    localparam int c_NBITS = 10;
`endif
    localparam int c_IDXW = $clog2(c_NBITS);

    logic [c_CNTW-1:0]  r_cnt;
    logic [c_IDXW-1:0]  r_idx;
    logic [c_NBITS-2:0] r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               w_bit_end;
    logic               w_done;
    logic [c_NBITS-2:0] w_frame;

    // Bits still to go after the start bit, LSB shifted out first; stop bit on top.
`ifdef AVG_UART_PARITY_EN
    assign w_frame = {1'b1, ^data, data};
`else
    assign w_frame = {1'b1, data};
`endif

    assign w_bit_end = (r_cnt == c_CNTW'(c_DIV - 1));
    assign w_done    = r_busy && w_bit_end && (r_idx == c_IDXW'(c_NBITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '1;
        end else if (start && (!r_busy || w_done)) begin
            // Accepting in the done cycle keeps consecutive bytes gapless.
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= w_frame;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_idx == c_IDXW'(c_NBITS - 1)) begin
                    r_busy <= 1'b0;
                end else begin
                    r_idx   <= r_idx + c_IDXW'(1);
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[c_NBITS-2:1]};
                end
            end else begin
                r_cnt <= r_cnt + c_CNTW'(1);
            end
        end
    end

    assign tx   = r_tx;
    assign done = w_done;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/avg_uart_reporter.sv
// +----------------------------------------------------------------------+
// | avg_uart_reporter                                                    |
// | Buffers moving-average results and prints them as hex + CR LF over a |
// | UART. Optional even parity via macro AVG_UART_PARITY_EN.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module avg_uart_reporter
    import avg_uart_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_avg,
    output logic             tx,
    output logic             busy,
    output logic             overflow
);

    localparam int c_NDIG = WIDTH / 4;
    localparam int c_PW   = $clog2(FIFO_DEPTH);
    localparam int c_CW   = $clog2(FIFO_DEPTH + 1);
    localparam int c_DW   = $clog2(c_NDIG + 1);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;
    logic             r_busy;
    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [c_DW-1:0]  r_d;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_start;
    logic [7:0]       w_data;
    logic             w_done;
    logic             w_tx_busy;
    logic [WIDTH-1:0] w_sh_next;

    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_push    = in_valid && (!w_full || w_pop);
    assign w_sh_next = r_sh << 4;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_avg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && !w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (r_count != '0) || (r_state != S_IDLE) || w_tx_busy;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sh    <= r_mem[r_rd_ptr];
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_d     <= c_DW'(c_NDIG);
                    r_state <= S_DIGIT;
                end
                S_DIGIT: begin
                    if (w_done) begin
                        r_sh <= w_sh_next;
                        r_d  <= r_d - c_DW'(1);
                        if (r_d == c_DW'(1))
                            r_state <= S_CR;
                    end
                end
                S_CR: begin
                    if (w_done)
                        r_state <= S_LF;
                end
                S_LF: begin
                    if (w_done)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The next byte must be presented in the done cycle for gapless output.
    always_comb begin
        w_start = 1'b0;
        w_data  = 8'h00;
        case (r_state)
            S_LOAD: begin
                w_start = 1'b1;
                w_data  = nib2asc(r_sh[WIDTH-1 -: 4]);
            end
            S_DIGIT: begin
                w_start = w_done;
                w_data  = (r_d == c_DW'(1)) ? ASC_CR : nib2asc(w_sh_next[WIDTH-1 -: 4]);
            end
            S_CR: begin
                w_start = w_done;
                w_data  = ASC_LF;
            end
            default: begin
                w_start = 1'b0;
                w_data  = 8'h00;
            end
        endcase
    end

    uart_tx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .data  (w_data),
        .tx    (tx),
        .done  (w_done),
        .busy  (w_tx_busy)
    );

    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_avg_uart_reporter.sv
// +----------------------------------------------------------------------+
// | tb_avg_uart_reporter                                                 |
// | Scoreboard bench: decodes the tx line and compares against frames    |
// | queued at stimulus time. Honours AVG_UART_PARITY_EN.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_avg_uart_reporter;

    localparam int c_DIV = 16;
`ifdef AVG_UART_PARITY_EN
    localparam int c_NB = 11;
`else
    localparam int c_NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_avg = '0;
    logic        tx;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_send   = 0;

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       stp;
        int         sc;
    } rx_t;

    rx_t         rx_q [$];
    logic [31:0] exp_q [$];

    avg_uart_reporter #(
        .WIDTH      (32),
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_avg   (in_avg),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples each bit mid-period on falling clock edges.
    initial begin : mon
        rx_t r;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                r.sc  = cyc;
                r.par = 1'b0;
                r.b   = 8'h00;
                repeat (c_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_DIV) @(negedge clk);
                    r.b[i] = tx;
                end
`ifdef AVG_UART_PARITY_EN
                repeat (c_DIV) @(negedge clk);
                r.par = tx;
`endif
                repeat (c_DIV) @(negedge clk);
                r.stp = tx;
                rx_q.push_back(r);
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int k);
        logic [3:0] n;
        if (k == 8) return 8'h0D;
        if (k == 9) return 8'h0A;
        n = v[31 - 4*k -: 4];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] v, input bit keep);
        @(negedge clk);
        in_valid = 1'b1;
        in_avg   = v;
        t_send   = cyc;
        if (keep) exp_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input bit chk_lat);
        logic [31:0] v;
        rx_t         r;
        int          n;
        int          prev;
        n    = 0;
        prev = 0;
        while (rx_q.size() < 10 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrived"}, 32'(rx_q.size() >= 10), 32'd1);
        chk({tag, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
        if (rx_q.size() >= 10 && exp_q.size() > 0) begin
            v = exp_q.pop_front();
            for (int k = 0; k < 10; k++) begin
                r = rx_q.pop_front();
                chk($sformatf("%s_byte%0d", tag, k), {24'h0, r.b}, {24'h0, exp_byte(v, k)});
                chk($sformatf("%s_stop%0d", tag, k), {31'h0, r.stp}, 32'd1);
`ifdef AVG_UART_PARITY_EN
                chk($sformatf("%s_par%0d", tag, k), {31'h0, r.par}, {31'h0, ^exp_byte(v, k)});
`endif
                if (k == 0 && chk_lat)
                    chk({tag, "_latency"}, r.sc, t_send + 3);
                if (k > 0)
                    chk($sformatf("%s_gap%0d", tag, k), r.sc - prev, c_NB * c_DIV);
                prev = r.sc;
            end
        end
    endtask

    initial begin : main
        int avg_seq [4];
        int win [8];
        int n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx", {31'h0, tx}, 32'd1);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_ovf", {31'h0, overflow}, 32'd0);

        // Single positive value
        send(32'd5, 1'b1);
        repeat (4) @(negedge clk);
        chk("single_busy_on", {31'h0, busy}, 32'd1);
        check_frame("single5", 1'b1);
        repeat (12) @(negedge clk);
        chk("single_busy_off", {31'h0, busy}, 32'd0);
        chk("single_ovf", {31'h0, overflow}, 32'd0);

        // Negative value, raw two's complement
        send(32'hFFFF_FFFD, 1'b1);
        check_frame("neg3", 1'b1);
        repeat (20) @(negedge clk);

        // Sliding-window averages of 2..8 with a length-4 window
        for (int i = 0; i < 7; i++) win[i] = i + 2;
        for (int i = 0; i < 4; i++)
            avg_seq[i] = (win[i] + win[i+1] + win[i+2] + win[i+3]) / 4;
        for (int i = 0; i < 4; i++) begin
            send(32'(avg_seq[i]), 1'b1);
            check_frame($sformatf("stream%0d", i), 1'b1);
            repeat (100) @(negedge clk);
        end
        chk("stream_ovf", {31'h0, overflow}, 32'd0);

        // Six back-to-back strobes: the sixth finds the FIFO full
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_avg   = 32'(i);
            if (i == 1) t_send = cyc;
            if (i <= 5) exp_q.push_back(32'(i));
            if (i == 6) chk("burst_ovf_before", {31'h0, overflow}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("burst_ovf_set", {31'h0, overflow}, 32'd1);
        check_frame("burst1", 1'b1);
        for (int i = 2; i <= 5; i++)
            check_frame($sformatf("burst%0d", i), 1'b0);
        repeat (40) @(negedge clk);
        chk("burst_no_sixth", rx_q.size(), 0);
        chk("burst_ovf_sticky", {31'h0, overflow}, 32'd1);

        // Reset during the fourth byte with a second result still buffered
        send(32'h1234_5678, 1'b0);
        send(32'h9999_9999, 1'b0);
        n = 0;
        while (rx_q.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_reached", 32'(rx_q.size() >= 3), 32'd1);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_tx", {31'h0, tx}, 32'd1);
        chk("midreset_ovf", {31'h0, overflow}, 32'd0);
        chk("midreset_busy", {31'h0, busy}, 32'd0);
        repeat (200) @(negedge clk);
        rx_q.delete();
        repeat (100) @(negedge clk);
        chk("midreset_fifo_empty", rx_q.size(), 0);
        chk("midreset_idle", {31'h0, busy}, 32'd0);
        send(32'h0000_001A, 1'b1);
        check_frame("after_reset", 1'b1);
        repeat (20) @(negedge clk);
        chk("final_busy", {31'h0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
